// File: rtl/radix4_sample_loader_if.sv
// rtl/radix4_sample_loader_if.sv - frame valid/ready stream between the loader and the radix-4 butterfly
// The loader drives the master side. The butterfly consumer takes the slave side.
interface radix4_sample_loader_if #(
    parameter int DATA_W = 16
);
    logic [4*DATA_W-1:0] frame_out;
    logic                frame_valid;
    logic                frame_ready;

    modport master (
        output frame_out,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_out,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/radix4_sample_loader.sv
// rtl/radix4_sample_loader.sv - packs four tick-captured samples into a frame for the radix-4 butterfly
// Define LOADER_OVERRUN_CNT_EN to add the saturating overrun_cnt output.
module radix4_sample_loader #(
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick_in,
    input  logic [DATA_W-1:0]         sample_in,
    radix4_sample_loader_if.master    frame_if,
    output logic [1:0]                fill_cnt,
`ifdef LOADER_OVERRUN_CNT_EN
    output logic [7:0]                overrun_cnt,
`endif
    output logic                      overrun
);
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

    out_state_t              state_q, state_d;
    logic                    tick_q;
    logic [1:0]              fill_cnt_q, fill_cnt_d;
    logic [2:0][DATA_W-1:0]  slot_q, slot_d;
    logic [4*DATA_W-1:0]     frame_q, frame_d;
    logic                    overrun_q, overrun_d;

    logic capture;
    logic complete;
    logic out_free;
    logic load;
    logic drop;

    // Only the rising edge counts, so a tick held high for several cycles captures once.
    assign capture  = tick_in & ~tick_q;
    assign complete = capture && (fill_cnt_q == 2'd3);
    assign out_free = (state_q == ST_EMPTY) || frame_if.frame_ready;
    assign load     = complete && out_free;
    assign drop     = complete && !out_free;

    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        slot_d     = slot_q;
        frame_d    = frame_q;
        overrun_d  = overrun_q | drop;

        if (capture) begin
            // Slot 3 is never stored: the live sample goes straight into the frame.
            fill_cnt_d = fill_cnt_q + 2'd1;
            case (fill_cnt_q)
                2'd0:    slot_d[0] = sample_in;
                2'd1:    slot_d[1] = sample_in;
                2'd2:    slot_d[2] = sample_in;
                default: ;
            endcase
        end

        if (load) begin
            frame_d = {sample_in, slot_q[2], slot_q[1], slot_q[0]};
        end

        case (state_q)
            ST_EMPTY: begin
                if (load) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (load) begin
                    state_d = ST_FULL;
                end else if (frame_if.frame_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            tick_q     <= 1'b1;
            fill_cnt_q <= 2'd0;
            slot_q     <= '0;
            frame_q    <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_in;
            fill_cnt_q <= fill_cnt_d;
            slot_q     <= slot_d;
            frame_q    <= frame_d;
            overrun_q  <= overrun_d;
        end
    end

`ifdef LOADER_OVERRUN_CNT_EN
    logic [7:0] overrun_cnt_q, overrun_cnt_d;

    always_comb begin
        overrun_cnt_d = overrun_cnt_q;
        if (drop && (overrun_cnt_q != 8'hFF)) begin
            overrun_cnt_d = overrun_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt_q <= 8'd0;
        end else begin
            overrun_cnt_q <= overrun_cnt_d;
        end
    end

    assign overrun_cnt = overrun_cnt_q;
`endif

    assign frame_if.frame_out   = frame_q;
    assign frame_if.frame_valid = (state_q == ST_FULL);
    assign fill_cnt             = fill_cnt_q;
    assign overrun              = overrun_q;
endmodule

// File: tb/tb_radix4_sample_loader.sv
// tb/tb_radix4_sample_loader.sv - directed self-checking bench for radix4_sample_loader
module tb_radix4_sample_loader;
    localparam int DATA_W = 16;

    logic              clk;
    logic              rst_n;
    logic              tick_in;
    logic [DATA_W-1:0] sample_in;
    logic [1:0]        fill_cnt;
    logic              overrun;
`ifdef LOADER_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    radix4_sample_loader_if #(.DATA_W(DATA_W)) frame_if ();

    radix4_sample_loader #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .sample_in (sample_in),
        .frame_if  (frame_if.master),
        .fill_cnt  (fill_cnt),
`ifdef LOADER_OVERRUN_CNT_EN
        .overrun_cnt (overrun_cnt),
`endif
        .overrun   (overrun)
    );

    int checks = 0;
    int errors = 0;
    int accept_cnt = 0;
    int acc_base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && frame_if.frame_valid && frame_if.frame_ready) begin
            accept_cnt <= accept_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Raise tick with a sample, hold it for hold cycles, then drop it; returns 1 ns after the last high edge.
    task automatic tick_pulse(input logic [DATA_W-1:0] s, input int hold);
        tick_in   = 1'b1;
        sample_in = s;
        for (int i = 0; i < hold; i++) begin
            next_cycle();
        end
        tick_in = 1'b0;
    endtask

    initial begin
        rst_n                = 1'b0;
        tick_in              = 1'b1;
        sample_in            = '0;
        frame_if.frame_ready = 1'b1;

        // Reset with tick already high
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", {63'd0, frame_if.frame_valid}, 64'd0);
        check_eq("rst_frame", frame_if.frame_out, 64'd0);
        check_eq("rst_fill", {62'd0, fill_cnt}, 64'd0);
        check_eq("rst_overrun", {63'd0, overrun}, 64'd0);
        rst_n = 1'b1;
        repeat (3) next_cycle();
        check_eq("held_tick_no_capture", {62'd0, fill_cnt}, 64'd0);
        tick_in = 1'b0;
        next_cycle();

        // Four single-cycle ticks with ready high
        for (int i = 1; i <= 3; i++) begin
            tick_pulse(DATA_W'(i), 1);
            next_cycle();
        end
        check_eq("fill_after_3", {62'd0, fill_cnt}, 64'd3);
        check_eq("valid_before_4th", {63'd0, frame_if.frame_valid}, 64'd0);
        tick_pulse(16'h0004, 1);
        check_eq("frame_1234", frame_if.frame_out, 64'h0004_0003_0002_0001);
        check_eq("valid_after_4th", {63'd0, frame_if.frame_valid}, 64'd1);
        check_eq("fill_wrap", {62'd0, fill_cnt}, 64'd0);
        next_cycle();
        check_eq("valid_one_cycle", {63'd0, frame_if.frame_valid}, 64'd0);
        check_eq("no_overrun_1", {63'd0, overrun}, 64'd0);

        // Ticks held high for 5 cycles
        acc_base = accept_cnt;
        tick_pulse(16'h0011, 5);
        next_cycle();
        check_eq("long_tick_fill1", {62'd0, fill_cnt}, 64'd1);
        tick_pulse(16'h0012, 5);
        next_cycle();
        check_eq("long_tick_fill2", {62'd0, fill_cnt}, 64'd2);
        tick_pulse(16'h0013, 5);
        next_cycle();
        tick_pulse(16'h0014, 5);
        next_cycle();
        check_eq("long_tick_frame", frame_if.frame_out, 64'h0014_0013_0012_0011);
        check_eq("long_tick_one_frame", 64'(accept_cnt - acc_base), 64'd1);
        check_eq("long_tick_fill0", {62'd0, fill_cnt}, 64'd0);

        // Ready low, eight ticks: second frame dropped
        frame_if.frame_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick_pulse(DATA_W'(i), 1);
            next_cycle();
        end
        check_eq("drop_frame_kept", frame_if.frame_out, 64'h0004_0003_0002_0001);
        check_eq("drop_valid", {63'd0, frame_if.frame_valid}, 64'd1);
        check_eq("drop_overrun", {63'd0, overrun}, 64'd1);
        check_eq("drop_fill0", {62'd0, fill_cnt}, 64'd0);
`ifdef LOADER_OVERRUN_CNT_EN
        check_eq("drop_cnt", {56'd0, overrun_cnt}, 64'd1);
`endif

        // Ready rises on the edge that completes 5..8: reload without a new drop
        for (int i = 5; i <= 7; i++) begin
            tick_pulse(DATA_W'(i), 1);
            next_cycle();
        end
        frame_if.frame_ready = 1'b1;
        tick_pulse(16'h0008, 1);
        frame_if.frame_ready = 1'b0;
        check_eq("reload_valid", {63'd0, frame_if.frame_valid}, 64'd1);
        check_eq("reload_frame", frame_if.frame_out, 64'h0008_0007_0006_0005);
`ifdef LOADER_OVERRUN_CNT_EN
        check_eq("reload_cnt", {56'd0, overrun_cnt}, 64'd1);
`endif
        next_cycle();
        check_eq("reload_hold", frame_if.frame_out, 64'h0008_0007_0006_0005);

        // Async reset mid-fill with a frame pending
        tick_pulse(16'h000A, 1);
        next_cycle();
        tick_pulse(16'h000B, 1);
        next_cycle();
        check_eq("pre_reset_fill", {62'd0, fill_cnt}, 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_valid", {63'd0, frame_if.frame_valid}, 64'd0);
        check_eq("async_frame", frame_if.frame_out, 64'd0);
        check_eq("async_fill", {62'd0, fill_cnt}, 64'd0);
        check_eq("async_overrun", {63'd0, overrun}, 64'd0);
`ifdef LOADER_OVERRUN_CNT_EN
        check_eq("async_cnt", {56'd0, overrun_cnt}, 64'd0);
`endif
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // Fresh frame needs four new ticks
        frame_if.frame_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick_pulse(DATA_W'(16'h0020 + i), 1);
            next_cycle();
        end
        check_eq("post_reset_no_frame", {63'd0, frame_if.frame_valid}, 64'd0);
        tick_pulse(16'h0024, 1);
        check_eq("post_reset_valid", {63'd0, frame_if.frame_valid}, 64'd1);
        check_eq("post_reset_frame", frame_if.frame_out, 64'h0024_0023_0022_0021);
        next_cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/radix4_sample_loader.md
# radix4_sample_loader

Downstream consumer of the clock divider's one-cycle tick (`output_clk`, synchronous to `clk`). Captures one input sample per tick rising edge and packs four consecutive samples into a frame for the radix-4 butterfly. Presents the frame with a valid/ready handshake. A separate fill buffer and output register let capture continue while a frame waits for acceptance.

## Interface
- `DATA_W`, 16, width of one sample
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `tick_in`  in  1  divider tick, synchronous to `clk`; capture on rising edge only
- `sample_in`  in  DATA_W  sample, valid on the cycle `tick_in` rises
- `frame_out`  out  4*DATA_W  packed frame; slot k at bits [k*DATA_W +: DATA_W], slot 0 = oldest
- `frame_valid`  out  1  frame_out holds an unaccepted frame
- `frame_ready`  in  1  downstream accepts when high together with frame_valid
- `fill_cnt`  out  2  samples currently in fill buffer (0–3)
- `overrun`  out  1  sticky: a completed frame was dropped
- `overrun_cnt`  out  8  present only with `LOADER_OVERRUN_CNT_EN`

## Operation
- Edge detect: `tick_q` registers `tick_in`. A capture occurs when `tick_in`=1 and `tick_q`=0. A tick held high for several cycles yields exactly one capture.
- Capture: `sample_in` is written to fill slot `fill_cnt`, and `fill_cnt` increments, wrapping 3→0.
- Frame completion is the capture into slot 3. On that edge the four slots, including the current sample, are the candidate frame.
  - If output is free (`frame_valid`=0, or `frame_valid`=1 and `frame_ready`=1 this cycle): load `frame_out` and set `frame_valid`=1.
  - Otherwise: drop the candidate, set `overrun`=1, leave `frame_out`/`frame_valid` unchanged, and return `fill_cnt` to 0.
- Handshake: `frame_valid` and `frame_ready` both high at a rising edge means accepted. `frame_valid` then clears unless a new frame loads on the same edge, in which case it stays 1 with new data.
- While `frame_valid`=1, `frame_out` is stable and independent of `frame_ready`. `frame_valid` never depends combinationally on `frame_ready`.
- Output-side states: EMPTY (`frame_valid`=0) and FULL (`frame_valid`=1).
  - EMPTY→FULL on frame completion.
  - FULL→EMPTY on handshake with no completion.
  - FULL→FULL on handshake plus completion (reload), or on completion without handshake (drop and overrun).
- `overrun` clears only on reset.

## Timing
- Reset values:
  - `frame_valid`=0, `frame_out`=0, `fill_cnt`=0, `overrun`=0, fill slots=0.
  - `tick_q`=1, so a tick already high at reset release is not captured.
  - `overrun_cnt`=0.
- Latency: `frame_valid` rises on the same clock edge that captures the 4th sample, i.e. registered and visible the following cycle.
- Minimum tick spacing: 2 cycles (high, low). The divider's 32-cycle period gives one frame per 128 cycles.
- Reset asserted mid-frame discards partial fill and any pending frame immediately. There is no output glitch beyond the async clear.
- Simultaneous events:
  - Capture into slot 0 with handshake on the same edge: both take effect independently.
  - Completion with handshake: reload, no overrun.

## Configuration
- `LOADER_OVERRUN_CNT_EN`
  - Defined: `overrun_cnt` port exists. It increments on every dropped frame and saturates at 255. It resets only on `rst_n`.
  - Undefined: port and counter are absent. The sticky `overrun` flag behaves identically in both builds.

## Test plan
- Reset release with `tick_in`=1 held → no capture, `fill_cnt`=0. The first capture happens only after tick goes 0→1.
- Four single-cycle ticks, samples 0x0001,0x0002,0x0003,0x0004, `frame_ready`=1 → `frame_out`=0x0004_0003_0002_0001 and `frame_valid` high for exactly one cycle, `overrun`=0.
- Tick held high 5 cycles, then low, repeated 4 times → exactly 4 captures and one frame.
- `frame_ready`=0, eight ticks with samples 1..8 → `frame_out` stays 0x0004_0003_0002_0001, `overrun`=1, `fill_cnt`=0. With the macro, `overrun_cnt`=1.
- Raise `frame_ready` on the edge capturing the 8th sample (5..8) → `frame_valid` stays 1, `frame_out`=0x0008_0007_0006_0005, no overrun.
- Assert `rst_n`=0 after 2 captures with a frame pending → all outputs return to reset values asynchronously. The next frame needs 4 fresh ticks.
